mux_16_8_way: RTL and testbench



---
 rtl/mux_16_8_way_if.sv | 35 +++
 rtl/mux_16_8_way.sv | 63 ++++++
 tb/tb_mux_16_8_way.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mux_16_8_way_if.sv
// rtl/mux_16_8_way_if.sv - operand/select/result bundle for mux_16_8_way; load present with MUX_16_8_WAY_LOAD_EN
interface mux_16_8_way_if;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
    logic [15:0] e;
    logic [15:0] f;
    logic [15:0] g;
    logic [15:0] h;
    logic [2:0]  sel;
    logic [15:0] out;
    logic [15:0] out_q;
`ifdef MUX_16_8_WAY_LOAD_EN
    logic        load;
`endif

    // Caller side: drives operands and select, observes both results.
    modport master (
        output a, b, c, d, e, f, g, h, sel,
`ifdef MUX_16_8_WAY_LOAD_EN
        output load,
`endif
        input  out, out_q
    );

    // Mux side: consumes operands and select, produces both results.
    modport slave (
        input  a, b, c, d, e, f, g, h, sel,
`ifdef MUX_16_8_WAY_LOAD_EN
        input  load,
`endif
        output out, out_q
    );
endinterface

// File: rtl/mux_16_8_way.sv
// rtl/mux_16_8_way.sv - 16-bit 8:1 word mux with registered copy; MUX_16_8_WAY_LOAD_EN adds a load enable
module mux_16_8_way (
    output logic [15:0] out,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] out_q
`ifdef MUX_16_8_WAY_LOAD_EN
    ,
    input  logic        load
`endif
);

    // Port names and order are kept bare because existing callers connect positionally.

    logic [15:0] w_pair_ab;
    logic [15:0] w_pair_cd;
    logic [15:0] w_pair_ef;
    logic [15:0] w_pair_gh;
    logic [15:0] w_half_lo;
    logic [15:0] w_half_hi;
    logic [15:0] w_out;
    logic        w_load;
    logic [15:0] r_out_q;

    // 2-way mux tree: sel[0] within pairs, sel[1] between pairs, sel[2] between halves.
    always_comb begin
        w_pair_ab = sel[0] ? b : a;
        w_pair_cd = sel[0] ? d : c;
        w_pair_ef = sel[0] ? f : e;
        w_pair_gh = sel[0] ? h : g;
        w_half_lo = sel[1] ? w_pair_cd : w_pair_ab;
        w_half_hi = sel[1] ? w_pair_gh : w_pair_ef;
        w_out     = sel[2] ? w_half_hi : w_half_lo;
    end

`ifdef MUX_16_8_WAY_LOAD_EN
    assign w_load = load;
`else
    assign w_load = 1'b1;
`endif

    // Registered copy of the selected word; reset wins over load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_q <= 16'h0000;
        end else if (w_load) begin
            r_out_q <= w_out;
        end
    end

    assign out   = w_out;
    assign out_q = r_out_q;

endmodule

// File: tb/tb_mux_16_8_way.sv
// tb/tb_mux_16_8_way.sv - directed self-checking bench for mux_16_8_way
module tb_mux_16_8_way;

    logic clk;
    logic clk_run;
    logic reset;
    int   checks;
    int   errors;

    logic [15:0] exp_tbl [0:7];
    logic [15:0] prev_q;

    mux_16_8_way_if bus ();

    mux_16_8_way dut (
        .out   (bus.out),
        .a     (bus.a),
        .b     (bus.b),
        .c     (bus.c),
        .d     (bus.d),
        .e     (bus.e),
        .f     (bus.f),
        .g     (bus.g),
        .h     (bus.h),
        .sel   (bus.sel),
        .clk   (clk),
        .reset (reset),
        .out_q (bus.out_q)
`ifdef MUX_16_8_WAY_LOAD_EN
        ,
        .load  (bus.load)
`endif
    );

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_operands();
        bus.a = 16'h8000; bus.b = 16'h2000; bus.c = 16'h0800; bus.d = 16'h0200;
        bus.e = 16'h0080; bus.f = 16'h0020; bus.g = 16'h0008; bus.h = 16'h0002;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        clk_run = 1'b0;
        reset   = 1'b0;
        exp_tbl[0] = 16'h8000; exp_tbl[1] = 16'h2000;
        exp_tbl[2] = 16'h0800; exp_tbl[3] = 16'h0200;
        exp_tbl[4] = 16'h0080; exp_tbl[5] = 16'h0020;
        exp_tbl[6] = 16'h0008; exp_tbl[7] = 16'h0002;
`ifdef MUX_16_8_WAY_LOAD_EN
        bus.load = 1'b1;
`endif
        set_operands();
        bus.sel = 3'd0;

        // Combinational sweep, clock held static.
        for (int k = 0; k < 8; k++) begin
            bus.sel = 3'(k);
            #10;
            check($sformatf("comb_sel%0d", k), bus.out, exp_tbl[k]);
        end

        // Operand change under fixed select, still no clock.
        bus.sel = 3'b101;
        #10;
        bus.f = 16'hFFFF;
        #10;
        check("comb_f_change", bus.out, 16'hFFFF);

        // Reset for two edges.
        bus.f   = 16'h0020;
        bus.sel = 3'b000;
        bus.a   = 16'hA5A5;
        reset   = 1'b1;
        clk_run = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("reset_out_q", bus.out_q, 16'h0000);
        check("reset_out", bus.out, 16'hA5A5);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("release_out_q", bus.out_q, 16'hA5A5);

        // Clocked sweep: out_q trails out by one cycle.
        prev_q = 16'hA5A5;
        set_operands();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.sel = 3'(k);
            #1;
            check($sformatf("sweep_out_sel%0d", k), bus.out, exp_tbl[k]);
            check($sformatf("sweep_hold_sel%0d", k), bus.out_q, prev_q);
            @(posedge clk);
            #1;
            check($sformatf("sweep_q_sel%0d", k), bus.out_q, exp_tbl[k]);
            prev_q = exp_tbl[k];
        end

        // Simultaneous select and operand change right before an edge.
        @(negedge clk);
        bus.sel = 3'b010;
        bus.c   = 16'h1234;
        #1;
        check("simul_out", bus.out, 16'h1234);
        @(posedge clk);
        #1;
        check("simul_q", bus.out_q, 16'h1234);
        bus.c = 16'h0800;

`ifdef MUX_16_8_WAY_LOAD_EN
        // Load gating: out_q holds while load is low.
        @(negedge clk);
        bus.load = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.sel = 3'(k);
            @(posedge clk);
            #1;
            check($sformatf("load0_hold_sel%0d", k), bus.out_q, 16'h1234);
        end
        @(negedge clk);
        bus.load = 1'b1;
        @(posedge clk);
        #1;
        check("load1_capture", bus.out_q, 16'h0200);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_over_load", bus.out_q, 16'h0000);
        check("reset_over_load_out", bus.out, 16'h0200);
        @(negedge clk);
        reset = 1'b0;
`endif

        @(negedge clk);
        clk_run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
